// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/func
// codes, ALU operation codes and the per-state control word.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_R,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_JR,
    S_JAL,
    S_ERR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef struct packed {
    logic       reg_dst;
    logic       jal_reg;
    logic       pc_to_reg;
    logic       alu_src;
    logic       mem_to_reg;
    logic       jump_sel;
    logic       pc_jump;
    logic       pc_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_cntrl;
    logic       ir_write;
    logic       pc_write;
    logic       halted;
  } ctrl_t;

  // Control word for a state; ir_write/pc_write are still gated by the caller.
  // The ALU inputs stay selected through write-back and memory states so the
  // datapath sees a stable ALU result/address while it is consumed.
  function automatic ctrl_t state_ctrl(input state_t s, input logic [2:0] alu_op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_cntrl = ALU_ADD;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_EXEC_R: c.alu_cntrl = alu_op;
      S_WB_R: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_cntrl = alu_op;
      end
      S_EXEC_I: begin
        c.alu_src   = 1'b1;
        c.alu_cntrl = alu_op;
      end
      S_WB_I: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_cntrl = alu_op;
      end
      S_MEM_ADDR: begin
        c.alu_src   = 1'b1;
        c.alu_cntrl = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_cntrl = ALU_ADD;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_cntrl = ALU_ADD;
      end
      S_WB_MEM: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_cntrl = ALU_SUB;
        c.pc_src    = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_JUMP: begin
        c.pc_jump  = 1'b1;
        c.jump_sel = 1'b1;
        c.pc_write = 1'b1;
      end
      S_JR: begin
        c.pc_jump  = 1'b1;
        c.pc_write = 1'b1;
      end
      S_JAL: begin
        c.pc_jump   = 1'b1;
        c.jump_sel  = 1'b1;
        c.jal_reg   = 1'b1;
        c.pc_to_reg = 1'b1;
        c.reg_write = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_ERR: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_decode.sv
// Combinational ALU-operation decode from opcode/func, flagging R-type funcs
// the ALU cannot execute.
module mc_alu_decode
  import multi_cycle_controller_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [2:0] alu_cntrl,
  output logic       illegal
);

  always_comb begin
    alu_cntrl = ALU_ADD;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  alu_cntrl = ALU_ADD;
          FN_SUB:  alu_cntrl = ALU_SUB;
          FN_AND:  alu_cntrl = ALU_AND;
          FN_OR:   alu_cntrl = ALU_OR;
          FN_SLT:  alu_cntrl = ALU_SLT;
          default: illegal   = 1'b1;
        endcase
      end
      OP_BEQ:  alu_cntrl = ALU_SUB;
      OP_SLTI: alu_cntrl = ALU_SLT;
      default: alu_cntrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore FSM sequencing the MIPS datapath over fetch/decode/exec/mem/wb with a
// bounded wait on variable-latency memory and a retired-instruction counter.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             reg_dst,
  output logic             jal_reg,
  output logic             pc_to_reg,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             jump_sel,
  output logic             pc_jump,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       alu_cntrl,
  output logic             ir_write,
  output logic             pc_write,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [7:0] WAIT_MAX = 8'(WAIT_LIMIT);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl_q, ctrl_d;
  logic             retire;
  logic             mem_timeout;
  logic [2:0]       alu_op;
  logic             alu_illegal;
  logic             strobe_ok;

  mc_alu_decode u_alu_decode (
    .opcode    (opcode),
    .func      (func),
    .alu_cntrl (alu_op),
    .illegal   (alu_illegal)
  );

  // The limit cycle is the one where the counter already equals WAIT_LIMIT;
  // a mem_ready arriving in that cycle still completes the access.
  assign mem_timeout = (wait_q == WAIT_MAX);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (mem_timeout) state_d = S_ERR;
        else                  wait_d  = wait_q + 8'd1;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = (func == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:  state_d = S_MEM_ADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI,
          OP_SLTI:       state_d = S_EXEC_I;
          OP_J:          state_d = S_JUMP;
          OP_JAL:        state_d = S_JAL;
          default:       state_d = S_ERR;
        endcase
      end
      S_EXEC_R:   state_d = alu_illegal ? S_ERR : S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)        state_d = S_WB_MEM;
        else if (mem_timeout) state_d = S_ERR;
        else                  wait_d  = wait_q + 8'd1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (mem_timeout) begin
          state_d = S_ERR;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JR, S_JAL: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  // Control word is registered alongside the state so it is glitch-free.
  assign ctrl_d = state_ctrl(state_d, alu_op);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      retired_q <= '0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ctrl_q    <= ctrl_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign strobe_ok = (state_q == S_FETCH)  ? mem_ready :
                     (state_q == S_BRANCH) ? zero      : 1'b1;

  assign reg_dst    = ctrl_q.reg_dst;
  assign jal_reg    = ctrl_q.jal_reg;
  assign pc_to_reg  = ctrl_q.pc_to_reg;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign jump_sel   = ctrl_q.jump_sel;
  assign pc_jump    = ctrl_q.pc_jump;
  assign pc_src     = ctrl_q.pc_src;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_cntrl  = ctrl_q.alu_cntrl;
  assign ir_write   = ctrl_q.ir_write & strobe_ok;
  assign pc_write   = ctrl_q.pc_write & strobe_ok;
  assign halted     = ctrl_q.halted;
  assign retired    = retired_q;

endmodule
